fifo_umbral: RTL and testbench

//  Synchronous FIFO with programmable almost-full/almost-empty thresholds (umbrales).

---
 rtl/fifo_umbral_pkg.sv | 37 +++
 rtl/fifo_umbral_memoria_fifo.sv | 33 +++
 rtl/fifo_umbral.sv | 100 ++++++++++
 tb/tb_fifo_umbral.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_umbral_pkg.sv
// Shared definitions for the fifo_umbral family: default geometry, per-FIFO
// threshold widths and the per-edge accept decision.
package fifo_umbral_pkg;

  localparam int DATA_WIDTH_DEF = 6;
  localparam int ADDR_WIDTH_DEF = 2;

  // Threshold widths for the main, virtual-channel and destination FIFOs;
  // these must match the registers the control state machine latches.
  localparam int U_MFS = ADDR_WIDTH_DEF + 1;
  localparam int U_VCS = ADDR_WIDTH_DEF + 1;
  localparam int U_DS  = ADDR_WIDTH_DEF + 1;

  typedef struct packed {
    logic push_ok;
    logic pop_ok;
    logic overflow;
    logic underflow;
  } accept_t;

  // A pop on a full FIFO frees the slot the concurrent push needs, so the
  // push is accepted even though full is set before the edge.
  function automatic accept_t accept_decide(
    input logic push,
    input logic pop,
    input logic empty,
    input logic full
  );
    accept_t a;
    a.pop_ok    = pop & ~empty;
    a.push_ok   = push & (~full | pop);
    a.overflow  = push & full & ~pop;
    a.underflow = pop & empty;
    return a;
  endfunction

endpackage

// File: rtl/fifo_umbral_memoria_fifo.sv
// Register-file RAM for fifo_umbral: one write port and one registered read
// port whose output holds its value on cycles without a read.
module memoria_fifo #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: the storage array has no reset so it maps onto plain flops/RAM
  // cells; the top masks rd_data until the first accepted read.
  // NOTE: non-blocking writes let a read and a write to the same address on
  // one edge return the old word, which the full push+pop case relies on.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/fifo_umbral.sv
// Synchronous FIFO with programmable almost-full / almost-empty thresholds,
// sticky overflow/underflow error and a 1-cycle registered read.
module fifo_umbral
  import fifo_umbral_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  input  logic [ADDR_WIDTH:0]   umbral_alto,
  input  logic [ADDR_WIDTH:0]   umbral_bajo,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  error
);

  localparam int                CW    = ADDR_WIDTH + 1;
  localparam logic [CW-1:0]     DEPTH = CW'(1 << ADDR_WIDTH);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         count_next;
  logic                  valid_q;
  logic                  error_q;
  logic                  read_seen;
  logic [DATA_WIDTH-1:0] rd_data;
  accept_t               acc;

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH);

  // NOTE: every signal driven in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    acc        = accept_decide(push, pop, empty, full);
    count_next = count_q;
    unique case ({acc.push_ok, acc.pop_ok})
      2'b10:   count_next = count_q + CW'(1);
      2'b01:   count_next = count_q - CW'(1);
      default: count_next = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
      read_seen <= 1'b0;
    end else begin
      count_q <= count_next;
      valid_q <= acc.pop_ok;
      if (acc.push_ok) begin
        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      end
      if (acc.pop_ok) begin
        rd_ptr    <= rd_ptr + ADDR_WIDTH'(1);
        read_seen <= 1'b1;
      end
      if (acc.overflow || acc.underflow) begin
        error_q <= 1'b1;
      end
    end
  end

  memoria_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (acc.push_ok),
    .wr_addr (wr_ptr),
    .wr_data (data_in),
    .rd_en   (acc.pop_ok),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  // The RAM read register is not reset; data_out reads as zero until the
  // first accepted pop after reset, then follows the held read value.
  assign data_out     = read_seen ? rd_data : '0;
  assign valid_out    = valid_q;
  assign count        = count_q;
  assign error        = error_q;
  assign almost_full  = (umbral_alto != '0) && (count_q >= umbral_alto);
  assign almost_empty = (count_q <= umbral_bajo);

endmodule

// File: tb/tb_fifo_umbral.sv
// Self-checking bench for fifo_umbral: directed scenarios plus a randomized
// run, all checked against a queue-based reference model.
module tb_fifo_umbral;

  localparam int DW    = 6;
  localparam int AW    = 2;
  localparam int CW    = AW + 1;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          push;
  logic          pop;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic [CW-1:0] umbral_alto;
  logic [CW-1:0] umbral_bajo;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          almost_full;
  logic          almost_empty;
  logic          error;

  fifo_umbral #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .data_in      (data_in),
    .pop          (pop),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .umbral_alto  (umbral_alto),
    .umbral_bajo  (umbral_bajo),
    .count        (count),
    .empty        (empty),
    .full         (full),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .error        (error)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a plain queue of stored words plus the output registers.
  logic [DW-1:0] q[$];
  logic          m_err;
  logic          m_valid;
  logic [DW-1:0] m_dout;

  function automatic logic [CW-1:0] m_count();
    return CW'(q.size());
  endfunction

  function automatic logic m_af();
    return (umbral_alto != 0) && (q.size() >= int'(umbral_alto));
  endfunction

  function automatic logic m_ae();
    return q.size() <= int'(umbral_bajo);
  endfunction

  task automatic model_reset();
    q.delete();
    m_err   = 1'b0;
    m_valid = 1'b0;
    m_dout  = '0;
  endtask

  // Drive one cycle of stimulus, advance the model on the pre-edge state and
  // return at posedge+1 with push/pop released.
  task automatic step(input logic p, input logic [DW-1:0] d, input logic pp);
    bit was_empty, was_full;
    push      = p;
    data_in   = d;
    pop       = pp;
    was_empty = (q.size() == 0);
    was_full  = (q.size() == DEPTH);
    if ((p && was_full && !pp) || (pp && was_empty)) m_err = 1'b1;
    if (pp && !was_empty) begin
      m_dout  = q.pop_front();
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
    if (p && (!was_full || pp)) q.push_back(d);
    @(posedge clk);
    #1;
    push = 1'b0;
    pop  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset       = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    data_in     = '0;
    umbral_alto = 3'd3;
    umbral_bajo = 3'd1;
    #12;
    model_reset();
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", empty); end
    n_tests++; if (almost_empty !== 1'b1) begin n_fail++; $display("FAIL reset_almost_empty: got %b expected 1", almost_empty); end
    n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_tests++; if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b expected 0", error); end
    n_tests++; if (full !== 1'b0 || almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_full_flags: got full=%b af=%b expected 0/0", full, almost_full); end
    n_tests++; if (valid_out !== 1'b0 || data_out !== 6'h00) begin n_fail++; $display("FAIL reset_read_port: got valid=%b data=%h expected 0/00", valid_out, data_out); end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, DW'(i), 1'b0);
      n_tests++; if (count !== CW'(i)) begin n_fail++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, count, i); end
      n_tests++; if (almost_empty !== (i <= 1)) begin n_fail++; $display("FAIL fill_almost_empty[%0d]: got %b expected %b", i, almost_empty, (i <= 1)); end
      n_tests++; if (almost_full !== (i >= 3)) begin n_fail++; $display("FAIL fill_almost_full[%0d]: got %b expected %b", i, almost_full, (i >= 3)); end
      n_tests++; if (full !== (i == 4)) begin n_fail++; $display("FAIL fill_full[%0d]: got %b expected %b", i, full, (i == 4)); end
    end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= 4; i++) begin
      step(1'b0, '0, 1'b1);
      n_tests++; if (data_out !== DW'(i)) begin n_fail++; $display("FAIL drain_data[%0d]: got %h expected %h", i, data_out, DW'(i)); end
      n_tests++; if (valid_out !== 1'b1) begin n_fail++; $display("FAIL drain_valid[%0d]: got %b expected 1", i, valid_out); end
    end
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %b expected 1", empty); end
    step(1'b0, '0, 1'b0);
    n_tests++; if (valid_out !== 1'b0 || data_out !== 6'h04) begin n_fail++; $display("FAIL drain_idle: got valid=%b data=%h expected 0/04", valid_out, data_out); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++) step(1'b1, DW'($urandom_range(0, 62)), 1'b0);
    step(1'b1, 6'h3F, 1'b0);
    n_tests++; if (error !== 1'b1) begin n_fail++; $display("FAIL overflow_error: got %b expected 1", error); end
    n_tests++; if (count !== 3'd4 || full !== 1'b1) begin n_fail++; $display("FAIL overflow_count: got %0d full=%b expected 4/1", count, full); end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, 1'b1);
      n_tests++; if (data_out !== m_dout || data_out === 6'h3F) begin n_fail++; $display("FAIL overflow_drain[%0d]: got %h expected %h", i, data_out, m_dout); end
    end
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL overflow_empty: got %b expected 1", empty); end
  endtask

  task automatic test_underflow();
    do_reset();
    step(1'b1, 6'h2A, 1'b0);
    step(1'b0, '0, 1'b1);
    n_tests++; if (error !== 1'b0 || data_out !== 6'h2A) begin n_fail++; $display("FAIL underflow_pre: got err=%b data=%h expected 0/2a", error, data_out); end
    step(1'b0, '0, 1'b1);
    n_tests++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL underflow_valid: got %b expected 0", valid_out); end
    n_tests++; if (data_out !== 6'h2A) begin n_fail++; $display("FAIL underflow_data_hold: got %h expected 2a", data_out); end
    n_tests++; if (error !== 1'b1 || count !== 3'd0) begin n_fail++; $display("FAIL underflow_error: got err=%b count=%0d expected 1/0", error, count); end
    for (int i = 0; i < 3; i++) step(1'b1, DW'(i), 1'b0);
    n_tests++; if (error !== 1'b1) begin n_fail++; $display("FAIL underflow_sticky: got %b expected 1", error); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, DW'($urandom), 1'b0);
    step(1'b1, DW'($urandom), 1'b1);
    n_tests++; if (count !== 3'd4 || error !== 1'b0) begin n_fail++; $display("FAIL simul_full: got count=%0d err=%b expected 4/0", count, error); end
    n_tests++; if (data_out !== m_dout || valid_out !== 1'b1) begin n_fail++; $display("FAIL simul_full_data: got %h/%b expected %h/1", data_out, valid_out, m_dout); end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, 1'b1);
      n_tests++; if (data_out !== m_dout) begin n_fail++; $display("FAIL simul_drain[%0d]: got %h expected %h", i, data_out, m_dout); end
    end
    step(1'b1, DW'($urandom), 1'b1);
    n_tests++; if (count !== 3'd1 || error !== 1'b1 || valid_out !== 1'b0) begin n_fail++; $display("FAIL simul_empty: got count=%0d err=%b valid=%b expected 1/1/0", count, error, valid_out); end
    for (int i = 0; i < 10; i++) begin
      step(1'b1, DW'($urandom), 1'b1);
      n_tests++; if (data_out !== m_dout || valid_out !== 1'b1 || count !== 3'd1) begin n_fail++; $display("FAIL wrap[%0d]: got data=%h valid=%b count=%0d expected %h/1/1", i, data_out, valid_out, count, m_dout); end
    end
    step(1'b0, '0, 1'b1);
    n_tests++; if (data_out !== m_dout || empty !== 1'b1) begin n_fail++; $display("FAIL wrap_last: got %h empty=%b expected %h/1", data_out, empty, m_dout); end
  endtask

  task automatic test_threshold();
    do_reset();
    step(1'b1, 6'h11, 1'b0);
    step(1'b1, 6'h22, 1'b0);
    n_tests++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL thr_af_before: got %b expected 0", almost_full); end
    umbral_alto = 3'd1;
    #1;
    n_tests++; if (almost_full !== 1'b1) begin n_fail++; $display("FAIL thr_af_same_cycle: got %b expected 1", almost_full); end
    umbral_alto = 3'd0;
    step(1'b1, 6'h33, 1'b0);
    step(1'b1, 6'h34, 1'b0);
    n_tests++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL thr_af_disabled: got %b expected 0", almost_full); end
    umbral_alto = 3'd5;
    #1;
    n_tests++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL thr_af_above_depth: got %b expected 0", almost_full); end
    umbral_bajo = 3'd4;
    #1;
    n_tests++; if (almost_empty !== 1'b1) begin n_fail++; $display("FAIL thr_ae_at_depth: got %b expected 1", almost_empty); end
    umbral_bajo = 3'd3;
    #1;
    n_tests++; if (almost_empty !== 1'b0) begin n_fail++; $display("FAIL thr_ae_below: got %b expected 0", almost_empty); end
    umbral_alto = 3'd3;
    umbral_bajo = 3'd1;
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, DW'(i + 9), 1'b0);
    step(1'b1, 6'h3F, 1'b0);
    step(1'b0, '0, 1'b1);
    n_tests++; if (valid_out !== 1'b1 || error !== 1'b1 || data_out !== 6'h09) begin n_fail++; $display("FAIL areset_pre: got valid=%b err=%b data=%h expected 1/1/09", valid_out, error, data_out); end
    #2;
    reset = 1'b0;
    #1;
    n_tests++; if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL areset_count: got count=%0d empty=%b full=%b expected 0/1/0", count, empty, full); end
    n_tests++; if (almost_full !== 1'b0 || almost_empty !== 1'b1) begin n_fail++; $display("FAIL areset_flags: got af=%b ae=%b expected 0/1", almost_full, almost_empty); end
    n_tests++; if (valid_out !== 1'b0 || data_out !== 6'h00 || error !== 1'b0) begin n_fail++; $display("FAIL areset_outputs: got valid=%b data=%h err=%b expected 0/00/0", valid_out, data_out, error); end
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 6'h15, 1'b0);
    step(1'b0, '0, 1'b1);
    n_tests++; if (data_out !== 6'h15 || empty !== 1'b1) begin n_fail++; $display("FAIL areset_discard: got %h empty=%b expected 15/1", data_out, empty); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        umbral_alto = CW'($urandom_range(0, 7));
        umbral_bajo = CW'($urandom_range(0, 7));
      end
      step(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)));
      n_tests++;
      if (count !== m_count() || empty !== (q.size() == 0) || full !== (q.size() == DEPTH)) begin
        n_fail++; $display("FAIL rand_count[%0d]: got count=%0d e=%b f=%b expected %0d", i, count, empty, full, m_count());
      end
      n_tests++;
      if (almost_full !== m_af() || almost_empty !== m_ae()) begin
        n_fail++; $display("FAIL rand_almost[%0d]: got af=%b ae=%b expected %b/%b", i, almost_full, almost_empty, m_af(), m_ae());
      end
      n_tests++;
      if (valid_out !== m_valid || data_out !== m_dout || error !== m_err) begin
        n_fail++; $display("FAIL rand_read[%0d]: got v=%b d=%h e=%b expected %b/%h/%b", i, valid_out, data_out, error, m_valid, m_dout, m_err);
      end
    end
    umbral_alto = 3'd3;
    umbral_bajo = 3'd1;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_overflow();
    test_underflow();
    test_simultaneous();
    test_threshold();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
